lp_seg_counter: RTL and testbench
=================================

Name: lp_seg_counter

Overview:
- Parametrised synchronous up/down counter. It is the next-generation replacement for fixed 4-bit ripple counters in low-power timer and divider paths.
- Supports configurable width, a programmable terminal value, load, one-shot and free-run modes, and a terminal-count pulse.
- Count register is split into segments; each segment is written only when its carry/borrow-in is active, so idle upper bits never toggle.

Parameters:
- WIDTH, 8, counter width in bits (>=2).
- SEG, 4, segment width in bits; WIDTH must be an integer multiple of SEG.
- MAX_VAL, 2**WIDTH-1, terminal value when counting up and reload value when counting down; must be <= 2**WIDTH-1.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rstn  in  1  synchronous active-low reset, sampled on posedge clk.
- start  in  1  pulse: IDLE/DONE -> RUN.
- en  in  1  count enable while RUN; one step per cycle when high.
- up_dn  in  1  1 = count up, 0 = count down; sampled on every step.
- oneshot  in  1  1 = stop at terminal (DONE), 0 = wrap.
- clr  in  1  synchronous clear: count 0, state IDLE.
- load  in  1  load count from load_val.
- load_val  in  WIDTH  load value; values > MAX_VAL saturate to MAX_VAL.
- count  out  WIDTH  registered count.
- tc  out  1  registered one-cycle terminal-count pulse.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- gray_out  out  WIDTH  Gray code of count (see Optional Feature).

Behaviour:
- Reset: rstn low at posedge gives count=0, tc=0, busy=0, done=0, gray_out=0, state IDLE. This overrides all other inputs.
- Latency: every input is sampled at posedge; its effect is visible on outputs after that same edge (1 cycle).
- Priority, highest first: rstn, clr, load, start, step.
  - clr: count=0, state IDLE from any state.
  - load: count=min(load_val, MAX_VAL); state unchanged; no step in that cycle.
  - start: honoured only in IDLE/DONE and only when neither clr nor load is active.
- FSM:
  - IDLE: count holds; en is ignored. start -> RUN, count unchanged.
  - RUN: step when en=1; hold when en=0. start is ignored.
    - Up step: count+1, or terminal handling if count==MAX_VAL.
    - Down step: count-1, or terminal handling if count==0.
  - Terminal handling, free-run (oneshot=0): up wraps MAX_VAL->0; down wraps 0->MAX_VAL. Stay in RUN.
  - Terminal handling, one-shot (oneshot=1): reaching the terminal value (MAX_VAL up, 0 down) moves to DONE on the same edge that writes it. Count then holds.
  - DONE: count holds regardless of en or up_dn. start reloads count (0 if up_dn=1, MAX_VAL if up_dn=0) and moves to RUN.
- tc:
  - Free-run: high for exactly one cycle, on the edge that writes the terminal value (count==MAX_VAL up, count==0 down) by a step.
  - One-shot: high only on the edge that enters DONE.
  - Never asserted by load, clr, reset or start reload.
- Counting beyond MAX_VAL never occurs. Values are always in 0..MAX_VAL.
- Segment gating:
  - Segment k (bits k*SEG+SEG-1 : k*SEG) is written only when a step occurs and all lower segments are at their carry value (all-ones up, all-zeros down), or on load/clr/reset/reload/wrap.
  - Otherwise segment k flops hold via enable (clock-gate friendly, no feedback mux toggle).
- up_dn may change between any two steps. No glitch or extra step results.

Optional Feature:
- Macro LP_SEG_COUNTER_GRAY_EN.
- Defined: gray_out is a register updated on the same edge as count, holding count ^ (count >> 1). Reset value 0.
- Undefined: gray_out is tied to 0, no extra flops.

Test Plan:
- Reset: rstn=0 for 2 cycles with start=1, en=1, load=1 -> count=0, tc=0, busy=0, done=0; after release the FSM is in IDLE and count stays 0 with en=1.
- Free-run up: WIDTH=8, MAX_VAL=9; start, en=1 for 12 cycles -> count 1..9,0,1,2; tc high only in the cycle count=9; busy=1 throughout.
- One-shot down: load_val=3, start, oneshot=1, up_dn=0, en=1 -> 2,1,0, then done=1, tc pulses once, count holds 0 for 5 cycles. Next start -> count=9, busy=1.
- Enable gaps and segments: WIDTH=8, SEG=4, MAX_VAL=255, up; en pattern 1,0,1,1 from count 14 -> 15,15,16,17. Upper segment changes only on the 15->16 step.
- Priority: in RUN assert clr, load (load_val=5) and start together -> count=0, IDLE, tc=0. Then load_val=200 with MAX_VAL=9 -> count=9, tc=0.
- Gray (macro defined): count 6 -> gray_out 5; count 9 -> gray_out 13. Macro undefined -> gray_out stays 0.

Source files
------------

// File: rtl/lp_seg_counter.sv
`default_nettype none
// ============================================================================
// Module   : lp_seg_counter
// Brief    : Segmented low-power up/down counter with load, one-shot/free-run
//            modes, terminal-count pulse and optional Gray output
//            (enable with macro LP_SEG_COUNTER_GRAY_EN).
// Revision : 1.0 - initial release
// ============================================================================
module lp_seg_counter #(
    parameter int              WIDTH   = 8,
    parameter int              SEG     = 4,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             en,
    input  logic             up_dn,
    input  logic             oneshot,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gray_out
);
    localparam int               NSEG  = WIDTH / SEG;
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO  = '0;
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic             tc_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] next_val;
    logic [NSEG-1:0]  w_carry;

    logic             w_load;
    logic             w_start;
    logic             w_reload;
    logic             w_step;
    logic             w_wrap;
    logic             w_bulk;
    logic             w_hit;
    logic [WIDTH-1:0] w_load_sat;

    always_comb begin
        w_load     = !clr && load;
        w_start    = !clr && !load && start && (state_q != ST_RUN);
        w_reload   = w_start && (state_q == ST_DONE);
        w_step     = !clr && !load && (state_q == ST_RUN) && en;
        w_wrap     = w_step && (up_dn ? (count_q == MAX_V) : (count_q == ZERO));
        w_load_sat = (load_val > MAX_V) ? MAX_V : load_val;

        if (!rstn || clr) begin
            next_val = ZERO;
        end else if (w_load) begin
            next_val = w_load_sat;
        end else if (w_reload || w_wrap) begin
            next_val = up_dn ? ZERO : MAX_V;
        end else begin
            next_val = up_dn ? (count_q + ONE) : (count_q - ONE);
        end

        // Whole-word writes; ordinary steps only touch segments the carry reaches.
        w_bulk = !rstn || clr || w_load || w_reload || w_wrap;
        w_hit  = w_step && (up_dn ? (next_val == MAX_V) : (next_val == ZERO));
    end

`ifdef LP_SEG_COUNTER_GRAY_EN
    logic [WIDTH-1:0] count_d;
`endif

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        logic [SEG-1:0] seg_q;
        logic           w_seg_we;

        if (k == 0) begin : g_carry_base
            assign w_carry[k] = 1'b1;
        end else begin : g_carry_chain
            assign w_carry[k] = w_carry[k-1] &
                                (up_dn ? (&count_q[(k-1)*SEG +: SEG])
                                       : (~|count_q[(k-1)*SEG +: SEG]));
        end

        assign w_seg_we = w_bulk || (w_step && w_carry[k]);

        always_ff @(posedge clk) begin
            if (w_seg_we) begin
                seg_q <= next_val[k*SEG +: SEG];
            end
        end

        assign count_q[k*SEG +: SEG] = seg_q;
`ifdef LP_SEG_COUNTER_GRAY_EN
        assign count_d[k*SEG +: SEG] = w_seg_we ? next_val[k*SEG +: SEG] : seg_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tc_q <= w_hit;
            if (clr) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else if (w_start) begin
                state_q <= ST_RUN;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end else if (w_hit && oneshot) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end
    end

`ifdef LP_SEG_COUNTER_GRAY_EN
    logic [WIDTH-1:0] gray_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            gray_q <= ZERO;
        end else begin
            gray_q <= count_d ^ (count_d >> 1);
        end
    end

    assign gray_out = gray_q;
`else
    assign gray_out = ZERO;
`endif

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_lp_seg_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lp_seg_counter
// Brief    : Scoreboard bench for lp_seg_counter (MAX_VAL=9 and MAX_VAL=255).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lp_seg_counter;
    localparam int IDLE = 0;
    localparam int RUN  = 1;
    localparam int DONE = 2;

    typedef struct packed {
        logic [7:0] c;
        logic       tc;
        logic       busy;
        logic       done;
        logic [7:0] g;
    } obs_t;

    typedef struct {
        obs_t a;
        obs_t b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       oneshot = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;

    logic [7:0] cnt_a, gray_a, cnt_b, gray_b;
    logic       tc_a, busy_a, done_a, tc_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    int   m_cnt[2];
    int   m_st[2];
    bit   m_tc[2];

    always #5 clk = ~clk;

    lp_seg_counter #(.WIDTH(8), .SEG(4), .MAX_VAL(9)) dut_a (
        .clk(clk), .rstn(rstn), .start(start), .en(en), .up_dn(up_dn),
        .oneshot(oneshot), .clr(clr), .load(load), .load_val(load_val),
        .count(cnt_a), .tc(tc_a), .busy(busy_a), .done(done_a), .gray_out(gray_a)
    );

    lp_seg_counter #(.WIDTH(8), .SEG(4), .MAX_VAL(255)) dut_b (
        .clk(clk), .rstn(rstn), .start(start), .en(en), .up_dn(up_dn),
        .oneshot(oneshot), .clr(clr), .load(load), .load_val(load_val),
        .count(cnt_b), .tc(tc_b), .busy(busy_b), .done(done_b), .gray_out(gray_b)
    );

    // Reference behaviour for one counter instance over one clock edge.
    task automatic model(input int d, input int mx, input bit r, input bit s, input bit e,
                         input bit u, input bit o, input bit c, input bit l, input int lv);
        m_tc[d] = 1'b0;
        if (!r) begin
            m_cnt[d] = 0;
            m_st[d]  = IDLE;
        end else if (c) begin
            m_cnt[d] = 0;
            m_st[d]  = IDLE;
        end else if (l) begin
            m_cnt[d] = (lv > mx) ? mx : lv;
        end else if (s && m_st[d] != RUN) begin
            if (m_st[d] == DONE) m_cnt[d] = u ? 0 : mx;
            m_st[d] = RUN;
        end else if (m_st[d] == RUN && e) begin
            if (u) m_cnt[d] = (m_cnt[d] + 1) % (mx + 1);
            else   m_cnt[d] = (m_cnt[d] + mx) % (mx + 1);
            m_tc[d] = u ? (m_cnt[d] == mx) : (m_cnt[d] == 0);
            if (m_tc[d] && o) m_st[d] = DONE;
        end
    endtask

    function automatic obs_t expect_of(input int d);
        obs_t x;
        x.c    = 8'(m_cnt[d]);
        x.tc   = m_tc[d];
        x.busy = (m_st[d] == RUN);
        x.done = (m_st[d] == DONE);
`ifdef LP_SEG_COUNTER_GRAY_EN
        x.g    = 8'(m_cnt[d] ^ (m_cnt[d] >> 1));
`else
        x.g    = 8'd0;
`endif
        return x;
    endfunction

    task automatic apply(input bit r, input bit s, input bit e, input bit u,
                         input bit o, input bit c, input bit l, input int lv);
        exp_t x;
        @(negedge clk);
        rstn = r; start = s; en = e; up_dn = u; oneshot = o;
        clr = c; load = l; load_val = 8'(lv);
        model(0, 9, r, s, e, u, o, c, l, lv);
        model(1, 255, r, s, e, u, o, c, l, lv);
        x.a = expect_of(0);
        x.b = expect_of(1);
        exp_q.push_back(x);
    endtask

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: actual %0d required %0d", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                cmp("a.count", cnt_a, x.a.c);
                cmp("a.tc", tc_a, x.a.tc);
                cmp("a.busy", busy_a, x.a.busy);
                cmp("a.done", done_a, x.a.done);
                cmp("a.gray", gray_a, x.a.g);
                cmp("b.count", cnt_b, x.b.c);
                cmp("b.tc", tc_b, x.b.tc);
                cmp("b.busy", busy_b, x.b.busy);
                cmp("b.done", done_b, x.b.done);
                cmp("b.gray", gray_b, x.b.g);
            end
        end
    end

    initial begin : stimulus
        bit u, o;
        m_cnt = '{0, 0};
        m_st  = '{IDLE, IDLE};
        m_tc  = '{0, 0};

        // Reset overrides start/en/load, then IDLE ignores en.
        repeat (2) apply(0, 1, 1, 1, 0, 0, 1, 7);
        repeat (3) apply(1, 0, 1, 1, 0, 0, 0, 0);

        // Free-run up through the MAX_VAL=9 wrap.
        apply(1, 1, 1, 1, 0, 0, 0, 0);
        repeat (12) apply(1, 0, 1, 1, 0, 0, 0, 0);

        // One-shot down from 3, hold in DONE, restart reloads MAX_VAL.
        apply(1, 0, 0, 0, 1, 1, 0, 0);
        apply(1, 0, 0, 0, 1, 0, 1, 3);
        apply(1, 1, 0, 0, 1, 0, 0, 0);
        repeat (8) apply(1, 0, 1, 0, 1, 0, 0, 0);
        apply(1, 1, 1, 0, 1, 0, 0, 0);
        apply(1, 0, 0, 0, 1, 0, 0, 0);

        // Enable gaps across the segment boundary (14 -> 15,15,16,17 on MAX 255).
        apply(1, 0, 0, 1, 0, 1, 0, 0);
        apply(1, 0, 0, 1, 0, 0, 1, 14);
        apply(1, 1, 0, 1, 0, 0, 0, 0);
        apply(1, 0, 1, 1, 0, 0, 0, 0);
        apply(1, 0, 0, 1, 0, 0, 0, 0);
        repeat (2) apply(1, 0, 1, 1, 0, 0, 0, 0);

        // Priority: clr beats load and start; then saturating load.
        apply(1, 1, 1, 1, 0, 1, 1, 5);
        apply(1, 0, 1, 1, 0, 0, 1, 200);
        apply(1, 0, 0, 1, 0, 0, 1, 6);
        apply(1, 0, 0, 1, 0, 0, 1, 9);

        // Down wrap and direction changes in free-run.
        apply(1, 0, 0, 0, 0, 0, 1, 1);
        apply(1, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) apply(1, 0, 1, 0, 0, 0, 0, 0);
        repeat (3) apply(1, 0, 1, 1, 0, 0, 0, 0);

        // Randomized traffic.
        u = 1'b1;
        o = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0)  u = ~u;
            if ($urandom_range(31) == 0) o = ~o;
            apply($urandom_range(63) != 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
                  u, o, $urandom_range(47) == 0, $urandom_range(15) == 0,
                  int'($urandom_range(255)));
        end

        apply(1, 0, 0, 1, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
